popcount_ternary_acc: RTL and testbench

Streaming ternary-neuron accumulator that generalises our fixed 22-input popcount circuits. Each beat carries a `WIDTH`-bit positive-weight input vector and a `WIDTH`-bit negative-weight input vector. The block computes `popcount(pos) - popcount(neg)` per beat and accumulates that difference over `BEATS` beats. It then thresholds the total into a ternary activation. It sits between the sensor-side input serialiser and the neuron output register file, with valid/ready handshakes on both sides.

---
 rtl/popcount_ternary_acc.sv | 116 +++++++++++
 tb/tb_popcount_ternary_acc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_ternary_acc.sv
// Streaming ternary-neuron accumulator: per-beat popcount(pos)-popcount(neg) summed over BEATS beats, then thresholded.
// Define POPCOUNT_APPROX_LSB_EN for approximate popcounts (bit 0 of each per-beat count forced to 1).
module popcount_ternary_acc #(
  parameter int WIDTH = 22,
  parameter int BEATS = 4,
  parameter int ACC_W = $clog2(WIDTH*BEATS+1)+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pos,
  input  logic [WIDTH-1:0] in_neg,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [1:0]       out_act
);

  localparam int PC_W  = $clog2(WIDTH+1);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [PC_W-1:0]  w_pc_p, w_pc_n;
  logic [PC_W-1:0]  r_pc_p, r_pc_n;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_s1_vld, r_s1_last, r_s1_first;
  logic [ACC_W-1:0] r_acc, w_base, w_sum;
  logic             r_out_vld;
  logic [ACC_W-1:0] r_out_sum;
  logic [1:0]       r_out_act, w_act;
  logic             w_stall, w_in_acc, w_fire, w_cnt_last;

  always_comb begin
    w_pc_p = '0;
    w_pc_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pc_p = w_pc_p + PC_W'(in_pos[i]);
      w_pc_n = w_pc_n + PC_W'(in_neg[i]);
    end
`ifdef POPCOUNT_APPROX_LSB_EN
    w_pc_p[0] = 1'b1;
    w_pc_n[0] = 1'b1;
`endif
  end

  // Only a final beat can stall, and only while an unconsumed result occupies the buffer.
  assign w_stall    = r_s1_vld & r_s1_last & r_out_vld & ~out_ready;
  assign in_ready   = ~clear & (~r_s1_vld | ~w_stall);
  assign w_in_acc   = in_valid & in_ready;
  assign w_fire     = r_s1_vld & ~w_stall & ~clear;
  assign w_cnt_last = (r_beat_cnt == CNT_W'(BEATS-1));

  assign w_base = r_s1_first ? '0 : r_acc;
  assign w_sum  = w_base + ACC_W'(r_pc_p) - ACC_W'(r_pc_n);

  always_comb begin
    w_act = 2'b00;
    if ($signed(w_sum) >= $signed(thr_hi))      w_act = 2'b01;
    else if ($signed(w_sum) <= $signed(thr_lo)) w_act = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b0;
      r_pc_p     <= '0;
      r_pc_n     <= '0;
      r_beat_cnt <= '0;
    end else if (clear) begin
      r_s1_vld   <= 1'b0;
      r_beat_cnt <= '0;
    end else if (w_in_acc) begin
      r_s1_vld   <= 1'b1;
      r_s1_last  <= w_cnt_last;
      r_s1_first <= (r_beat_cnt == '0);
      r_pc_p     <= w_pc_p;
      r_pc_n     <= w_pc_n;
      r_beat_cnt <= w_cnt_last ? '0 : r_beat_cnt + CNT_W'(1);
    end else if (!w_stall) begin
      r_s1_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (w_fire) begin
      r_acc <= r_s1_last ? '0 : w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_sum <= '0;
      r_out_act <= 2'b00;
    end else if (w_fire && r_s1_last) begin
      r_out_vld <= 1'b1;
      r_out_sum <= w_sum;
      r_out_act <= w_act;
    end else if (out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_valid = r_out_vld;
  assign out_sum   = r_out_sum;
  assign out_act   = r_out_act;

endmodule

// File: tb/tb_popcount_ternary_acc.sv
// Directed and randomized checks of popcount_ternary_acc against a frame-level reference model.
module tb_popcount_ternary_acc;
  localparam int W  = 22;
  localparam int B  = 4;
  localparam int AW = $clog2(W*B+1)+1;

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_pos, in_neg;
  logic [AW-1:0] thr_hi, thr_lo, out_sum;
  logic [1:0]    out_act;

  always #5 clk = ~clk;

  popcount_ternary_acc #(.WIDTH(W), .BEATS(B), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_neg(in_neg),
    .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_act(out_act)
  );

  int total = 0;
  int bad   = 0;
  int m_beat = 0, m_acc = 0, m_hi = 0, m_lo = 0;
  int exp_sum[$];
  int exp_act[$];
  bit acc_seen;
  int bp_front;

  function automatic int pcm(logic [W-1:0] v);
    int c;
    c = $countones(v);
`ifdef POPCOUNT_APPROX_LSB_EN
    c = c | 1;
`endif
    return c;
  endfunction

  function automatic int actm(int s, int hi, int lo);
    if (s >= hi) return 1;
    if (s <= lo) return 3;
    return 0;
  endfunction

  function automatic logic [W-1:0] mk(int n);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(string tag, int obs, int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_thr(int hi, int lo);
    m_hi = hi; m_lo = lo;
    thr_hi = AW'(hi); thr_lo = AW'(lo);
  endtask

  // Called at a negedge with inputs already driven; models what the next posedge does.
  task automatic tick();
    #1;
    acc_seen = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_sum.size() == 0) check("unexpected_result", 1, 0);
      else begin
        check("sb_sum", int'($signed(out_sum)), exp_sum.pop_front());
        check("sb_act", int'(out_act), exp_act.pop_front());
      end
    end
    if (clear) begin
      m_beat = 0; m_acc = 0;
    end else if (in_valid && in_ready) begin
      acc_seen = 1'b1;
      m_acc += pcm(in_pos) - pcm(in_neg);
      if (m_beat == B-1) begin
        exp_sum.push_back(m_acc);
        exp_act.push_back(actm(m_acc, m_hi, m_lo));
        m_acc = 0; m_beat = 0;
      end else m_beat++;
    end
    @(negedge clk);
  endtask

  task automatic beat(logic [W-1:0] p, logic [W-1:0] n);
    in_valid = 1'b1; in_pos = p; in_neg = n;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc_seen) break;
    end
    if (!acc_seen) check("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 50; k++) begin
      if (out_valid) break;
      tick();
    end
    check("out_valid_wait", int'(out_valid), 1);
  endtask

  task automatic mixed_frame();
    beat(mk(3), mk(5));
    beat(mk(0), mk(7));
    beat(mk(2), mk(2));
    beat(mk(1), mk(4));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_pos = '0; in_neg = '0;
    out_ready = 1'b1;
    set_thr(10, -10);
    #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_act", int'(out_act), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full positive frame, latency two cycles after the last accept
    for (int i = 0; i < B; i++) beat(mk(W), '0);
    check("lat_t1_not_yet", int'(out_valid), 0);
    tick();
    check("lat_t2_valid", int'(out_valid), 1);
    check("fullpos_sum", int'($signed(out_sum)), 88);
    check("fullpos_act", int'(out_act), 1);
    tick();

    // Mixed frame under two lower thresholds
    mixed_frame();
    wait_out();
    check("mixed_sum", int'($signed(out_sum)), -12);
    check("mixed_act_neg", int'(out_act), 3);
    tick();
    set_thr(10, -20);
    mixed_frame();
    wait_out();
    check("mixed_act_zero", int'(out_act), 0);
    tick();
    set_thr(10, -10);

    // Backpressure: next frame accumulates behind a held result, final beat stalls
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < B; i++) beat(W'($urandom), W'($urandom));
    bp_front = exp_sum[0];
    in_valid = 1'b1; in_pos = W'($urandom); in_neg = W'($urandom);
    repeat (3) tick();
    #1;
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_out_held", int'(out_valid), 1);
    check("bp_sum_stable", int'($signed(out_sum)), bp_front);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_reload_valid", int'(out_valid), 1);
    check("bp_second_sum", int'($signed(out_sum)), exp_sum[0]);
    tick();

    // Clear mid-frame drops the partial sum and the beat presented with it
    beat(mk(5), '0);
    beat(mk(5), '0);
    clear = 1'b1; in_valid = 1'b1; in_pos = mk(5); in_neg = '0;
    #1;
    check("clear_in_ready_low", int'(in_ready), 0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < B; i++) beat(mk(1), '0);
    wait_out();
`ifdef POPCOUNT_APPROX_LSB_EN
    check("clear_sum", int'($signed(out_sum)), 0);
`else
    check("clear_sum", int'($signed(out_sum)), 4);
`endif
    tick();

    // Beats of (3,2): the approximate mode cancels the difference
    for (int i = 0; i < B; i++) beat(mk(3), mk(2));
    wait_out();
`ifdef POPCOUNT_APPROX_LSB_EN
    check("approx_sum", int'($signed(out_sum)), 0);
`else
    check("exact_sum_32", int'($signed(out_sum)), 4);
`endif
    tick();

    // Asynchronous reset with a pending result and a partial frame
    out_ready = 1'b0;
    for (int i = 0; i < B; i++) beat(W'($urandom), W'($urandom));
    wait_out();
    beat(W'($urandom), W'($urandom));
    beat(W'($urandom), W'($urandom));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_sum", int'(out_sum), 0);
    check("arst_out_act", int'(out_act), 0);
    check("arst_in_ready", int'(in_ready), 1);
    exp_sum.delete(); exp_act.delete(); m_beat = 0; m_acc = 0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < B; i++) beat(W'($urandom), W'($urandom));
    wait_out();
    tick();
    check("arst_frame_consumed", exp_sum.size(), 0);

    // Randomized traffic and backpressure, thresholds fixed per segment
    for (int seg = 0; seg < 3; seg++) begin
      set_thr(int'($urandom_range(30)) - 15, int'($urandom_range(30)) - 15);
      for (int c = 0; c < 300; c++) begin
        in_valid  = ($urandom % 4) != 0;
        in_pos    = W'($urandom);
        in_neg    = W'($urandom);
        out_ready = ($urandom % 3) != 0;
        tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) tick();
      check("rand_drain_empty", exp_sum.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
